// File: rtl/seq_shifter.sv
// Iterative one-bit-per-clock shifter with valid/ready handshakes on both sides.
// Optional macro SEQ_SHIFTER_ROTATE_EN turns the zero-filling shift into a rotate.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic             direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             carry_q, carry_d;
  logic             fill_s;
  logic             out_bit_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= {WIDTH{1'b0}};
      cnt_q   <= {SHW{1'b0}};
      dir_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      carry_q <= carry_d;
    end
  end

  // The bit leaving the register this step, and what enters the vacated end.
  always_comb begin
    out_bit_s = dir_q ? data_q[0] : data_q[WIDTH-1];
`ifdef SEQ_SHIFTER_ROTATE_EN
    fill_s = out_bit_s;
`else
    fill_s = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in;
          cnt_d   = shift;
          dir_d   = direction;
          carry_d = 1'b0;
          if (shift == {SHW{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (dir_q) begin
          data_d = {fill_s, data_q[WIDTH-1:1]};
        end else begin
          data_d = {data_q[WIDTH-2:0], fill_s};
        end
        carry_d = out_bit_s;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign out       = data_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed, table-driven bench for seq_shifter (default 8-bit / 3-bit shift amount).
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] sh;
  logic       dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       out_carry;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       dr;
    logic [7:0] eo;
    logic       ec;
  } vec_t;

  vec_t vecs [9];

  seq_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .shift     (sh),
    .direction (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic dr,
                        input logic [7:0] eo, input logic ec);
    int         lat;
    int         bcnt;
    logic       seen;
    logic [7:0] o;
    logic       c;
    lat = -1; bcnt = 0; seen = 1'b0; o = 8'h00; c = 1'b0;
    @(negedge clk);
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    din = d; sh = s; dir = dr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; din = 8'h5A; sh = 3'd6; dir = ~dr;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1; lat = k; o = dout; c = out_carry;
      end
      if (busy) bcnt++;
      else break;
    end
    check("latency", 32'(lat), 32'(s));
    check("out", 32'(o), 32'(eo));
    check("out_carry", 32'(c), 32'(ec));
    check("busy_cycles", 32'(bcnt), 32'(s) + 32'd1);
    check("in_ready_after_op", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] bp_exp;
    int         wcnt;
    int         spurious;
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; din = 8'h00; sh = 3'd0; dir = 1'b0; out_ready = 1'b1;

    vecs[0] = '{8'h40, 3'd1, 1'b0, 8'h80, 1'b0};
    vecs[1] = '{8'h40, 3'd1, 1'b1, 8'h20, 1'b0};
    vecs[3] = '{8'hA5, 3'd0, 1'b0, 8'hA5, 1'b0};
    vecs[5] = '{8'h01, 3'd7, 1'b0, 8'h80, 1'b0};
`ifdef SEQ_SHIFTER_ROTATE_EN
    vecs[2] = '{8'hF0, 3'd4, 1'b0, 8'h0F, 1'b1};
    vecs[4] = '{8'h81, 3'd3, 1'b1, 8'h30, 1'b0};
    vecs[6] = '{8'hFF, 3'd7, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h80, 3'd1, 1'b0, 8'h01, 1'b1};
    vecs[8] = '{8'h03, 3'd2, 1'b1, 8'hC0, 1'b1};
    bp_exp  = 8'h30;
`else
    vecs[2] = '{8'hF0, 3'd4, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h81, 3'd3, 1'b1, 8'h10, 1'b0};
    vecs[6] = '{8'hFF, 3'd7, 1'b1, 8'h01, 1'b1};
    vecs[7] = '{8'h80, 3'd1, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{8'h03, 3'd2, 1'b1, 8'h00, 1'b1};
    bp_exp  = 8'h10;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(dout), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].d, vecs[i].s, vecs[i].dr, vecs[i].eo, vecs[i].ec);
    end

    // Backpressure: result held, second operand ignored
    out_ready = 1'b0;
    @(negedge clk);
    din = 8'h81; sh = 3'd3; dir = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wcnt = 0;
    while (!out_valid && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    check("bp_latency", 32'(wcnt), 32'd3);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        din = 8'hFF; sh = 3'd0; dir = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check("bp_out", 32'(dout), 32'(bp_exp));
      check("bp_carry", 32'(out_carry), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_second_ignored", 32'(dout), 32'(bp_exp));

    // Reset in the third SHIFT cycle discards the operation
    din = 8'h01; sh = 3'd7; dir = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out", 32'(dout), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    spurious = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid || busy) spurious++;
    end
    check("mid_rst_no_result", 32'(spurious), 32'd0);

    // Operation after the aborted one still works
    run_op(8'h40, 3'd1, 1'b0, 8'h80, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
